// File: rtl/gdc_map_bank_reader_if.sv
// Stream handshake bundle used for both the bank-side input and the output.
interface gdc_map_bank_reader_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/gdc_map_bank_reader.sv
// Drains a frame of map blocks from round-robin buffer banks into a stream
// master through a 2-entry skid FIFO; tags block ends (tlast) and frame end (tuser).
module gdc_map_bank_reader #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BANKS  = 2,
  parameter int BEAT_W     = 12,
  parameter int BLK_W      = 12,
  parameter int SEL_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 soft_rstn,
  input  logic                 i_start,
  input  logic [BLK_W-1:0]     cfg_blocks,
  input  logic [BEAT_W-1:0]    cfg_block_beats,
  input  logic [BEAT_W-1:0]    cfg_last_beats,
  input  logic [NUM_BANKS-1:0] i_bank_full,
  output logic [SEL_W-1:0]     o_bank_sel,
  output logic [NUM_BANKS-1:0] o_bank_release,
  gdc_map_bank_reader_if.slave  s_axis,
  gdc_map_bank_reader_if.master m_axis,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_err
);

  typedef enum logic [2:0] {IDLE, WAIT_BANK, STREAM, RELEASE, DRAIN} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  user;
  } beat_t;

  state_e              state_q, state_d;
  logic                start_s1_q, start_s1_d, start_s2_q, start_s2_d;
  logic [BLK_W-1:0]    cfg_blocks_q, cfg_blocks_d;
  logic [BEAT_W-1:0]   cfg_block_beats_q, cfg_block_beats_d;
  logic [BEAT_W-1:0]   cfg_last_beats_q, cfg_last_beats_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  beat_t [1:0]         fifo_q, fifo_d;
  logic [1:0]          fill_q, fill_d;

  logic                start_edge, cfg_ok, last_blk, final_beat;
  logic [BEAT_W-1:0]   target;
  logic                s_rdy, accept, pop, wr_idx;
  logic [NUM_BANKS-1:0] release_oh;

  assign start_edge = start_s1_q & ~start_s2_q;
  assign cfg_ok     = (|cfg_blocks) & (|cfg_block_beats) & (|cfg_last_beats);
  assign last_blk   = (blk_cnt_q == cfg_blocks_q - BLK_W'(1));
  assign target     = last_blk ? cfg_last_beats_q : cfg_block_beats_q;
  assign final_beat = (beat_cnt_q == target - BEAT_W'(1));
  assign accept     = s_axis.tvalid & s_rdy;
  assign pop        = m_axis.tready & (fill_q != 2'd0);
  // Write slot: after a same-cycle pop the tail moves down one entry.
  assign wr_idx     = fill_q[0] & ~pop;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; soft reset forces IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_edge && cfg_ok) state_d = WAIT_BANK;
      WAIT_BANK: if (i_bank_full[ptr_q]) state_d = STREAM;
      STREAM:    if (accept && final_beat) state_d = RELEASE;
      RELEASE:   state_d = (blk_cnt_q + BLK_W'(1) == cfg_blocks_q) ? DRAIN : WAIT_BANK;
      DRAIN:     if (fill_q == 2'd0) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (!soft_rstn) state_d = IDLE;
  end

  // FSM outputs: input accept gate (independent of m_axis.tready) and release pulse.
  always_comb begin
    s_rdy      = (state_q == STREAM) && (fill_q < 2'd2) && (beat_cnt_q < target);
    release_oh = '0;
    if (state_q == RELEASE) release_oh[ptr_q] = 1'b1;
  end

  // Counters, config latch, status pulses and skid FIFO next values.
  always_comb begin
    start_s1_d        = i_start;
    start_s2_d        = start_s1_q;
    cfg_blocks_d      = cfg_blocks_q;
    cfg_block_beats_d = cfg_block_beats_q;
    cfg_last_beats_d  = cfg_last_beats_q;
    ptr_d             = ptr_q;
    blk_cnt_d         = blk_cnt_q;
    beat_cnt_d        = beat_cnt_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    err_d             = start_edge && ((state_q != IDLE) || !cfg_ok);
    fifo_d            = fifo_q;
    fill_d            = fill_q;

    if (state_q == IDLE && start_edge && cfg_ok) begin
      cfg_blocks_d      = cfg_blocks;
      cfg_block_beats_d = cfg_block_beats;
      cfg_last_beats_d  = cfg_last_beats;
      ptr_d             = '0;
      blk_cnt_d         = '0;
      beat_cnt_d        = '0;
      busy_d            = 1'b1;
    end
    if (accept) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    if (state_q == RELEASE) begin
      ptr_d      = (ptr_q == SEL_W'(NUM_BANKS - 1)) ? '0 : ptr_q + SEL_W'(1);
      blk_cnt_d  = blk_cnt_q + BLK_W'(1);
      beat_cnt_d = '0;
    end
    if (state_q == DRAIN && fill_q == 2'd0) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fill_d    = fill_q - 2'd1;
    end
    if (accept) begin
      fifo_d[wr_idx] = '{data: s_axis.tdata, last: final_beat, user: final_beat && last_blk};
      fill_d         = fill_d + 2'd1;
    end

    // Soft reset drops buffered beats and status; the start synchroniser keeps
    // tracking the pin so a held-high start does not fake an edge afterwards.
    if (!soft_rstn) begin
      cfg_blocks_d      = '0;
      cfg_block_beats_d = '0;
      cfg_last_beats_d  = '0;
      ptr_d             = '0;
      blk_cnt_d         = '0;
      beat_cnt_d        = '0;
      busy_d            = 1'b0;
      err_d             = 1'b0;
      fifo_d            = '0;
      fill_d            = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_s1_q        <= 1'b0;
      start_s2_q        <= 1'b0;
      cfg_blocks_q      <= '0;
      cfg_block_beats_q <= '0;
      cfg_last_beats_q  <= '0;
      ptr_q             <= '0;
      blk_cnt_q         <= '0;
      beat_cnt_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      fifo_q            <= '0;
      fill_q            <= '0;
    end else begin
      start_s1_q        <= start_s1_d;
      start_s2_q        <= start_s2_d;
      cfg_blocks_q      <= cfg_blocks_d;
      cfg_block_beats_q <= cfg_block_beats_d;
      cfg_last_beats_q  <= cfg_last_beats_d;
      ptr_q             <= ptr_d;
      blk_cnt_q         <= blk_cnt_d;
      beat_cnt_q        <= beat_cnt_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      err_q             <= err_d;
      fifo_q            <= fifo_d;
      fill_q            <= fill_d;
    end
  end

  assign s_axis.tready  = s_rdy;
  assign m_axis.tvalid  = (fill_q != 2'd0);
  assign m_axis.tdata   = fifo_q[0].data;
  assign m_axis.tlast   = fifo_q[0].last;
  assign m_axis.tuser   = fifo_q[0].user;
  assign o_bank_sel     = ptr_q;
  assign o_bank_release = release_oh;
  assign o_busy         = busy_q;
  assign o_frame_done   = done_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_gdc_map_bank_reader.sv
// Directed bench: a frame-level beat model (expected beat list, occupancy,
// release order) checked every cycle, plus literal tlast/tuser/release pins.
module tb_gdc_map_bank_reader;
  localparam int DW = 128, NB = 3, BW = 12, KW = 12, SW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  logic clk = 1'b0, rstn = 1'b0, soft_rstn = 1'b1, i_start = 1'b0;
  logic [KW-1:0] cfg_blocks = '0;
  logic [BW-1:0] cfg_block_beats = '0, cfg_last_beats = '0;
  logic [NB-1:0] i_bank_full = '1;
  logic [SW-1:0] o_bank_sel;
  logic [NB-1:0] o_bank_release;
  logic o_busy, o_frame_done, o_err;

  gdc_map_bank_reader_if #(.DATA_WIDTH(DW)) s_axis ();
  gdc_map_bank_reader_if #(.DATA_WIDTH(DW)) m_axis ();

  gdc_map_bank_reader #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .BEAT_W(BW), .BLK_W(KW)) dut (
    .clk(clk), .rstn(rstn), .soft_rstn(soft_rstn), .i_start(i_start),
    .cfg_blocks(cfg_blocks), .cfg_block_beats(cfg_block_beats), .cfg_last_beats(cfg_last_beats),
    .i_bank_full(i_bank_full), .o_bank_sel(o_bank_sel), .o_bank_release(o_bank_release),
    .s_axis(s_axis), .m_axis(m_axis),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int frame_no = 0, src_cnt = 0, mready_pct = 100;
  bit src_rst = 0;
  beat_t exp_q[$];
  int tlast_log[$], tuser_log[$], rel_log[$];
  int out_idx = 0, rel_count = 0, occ = 0, cyc = 0, first_out = 0, last_out = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int k);
    return {32'(frame_no), 32'(k), ~32'(k), 32'(k) * 32'h9e37};
  endfunction

  // Upstream bank source: presents beat src_cnt, advances on each handshake.
  // Also drives the downstream ready at the configured duty.
  initial begin
    bit acc;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
    m_axis.tready = 1'b1;
    forever begin
      @(negedge clk);
      acc = s_axis.tvalid && s_axis.tready && rstn && soft_rstn;
      @(posedge clk); #1;
      if (src_rst) begin src_cnt = 0; src_rst = 0; end
      else if (acc) src_cnt++;
      s_axis.tdata  = mk_data(src_cnt);
      s_axis.tvalid = rstn;
      m_axis.tready = ($urandom_range(99) < mready_pct);
    end
  end

  always @(negedge clk) if (rstn && o_err) err_cnt++;

  // Per-cycle compare against the frame model.
  initial begin
    bit in_x, out_x, prev_stall;
    logic [DW+1:0] prev_word;
    beat_t e;
    logic [NB-1:0] oh;
    prev_stall = 0; prev_word = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn || !soft_rstn) begin
        exp_q.delete(); occ = 0; prev_stall = 0;
      end else begin
        in_x  = s_axis.tvalid && s_axis.tready;
        out_x = m_axis.tvalid && m_axis.tready;
        chk("m_tvalid_vs_occupancy", m_axis.tvalid, occ != 0);
        if (occ == 2) chk("s_tready_low_when_full", s_axis.tready, 1'b0);
        if (prev_stall) begin
          chk("stall_hold_tvalid", m_axis.tvalid, 1'b1);
          chk("stall_hold_word", {m_axis.tdata, m_axis.tlast, m_axis.tuser}, prev_word);
        end
        if (out_x) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %0h with no beat expected", m_axis.tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_axis.tdata, e.d);
            chk("beat_tlast", m_axis.tlast, e.l);
            chk("beat_tuser", m_axis.tuser, e.u);
          end
          if (m_axis.tlast) tlast_log.push_back(out_idx);
          if (m_axis.tuser) tuser_log.push_back(out_idx);
          if (out_idx == 0) first_out = cyc;
          last_out = cyc;
          out_idx++;
        end
        if (o_bank_release != '0) begin
          oh = '0; oh[rel_count % NB] = 1'b1;
          chk("release_onehot", o_bank_release, oh);
          rel_log.push_back(int'(o_bank_sel));
          rel_count++;
        end
        occ = occ + int'(in_x) - int'(out_x);
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev_word  = {m_axis.tdata, m_axis.tlast, m_axis.tuser};
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1; tick(); tick(); i_start = 1'b0;
  endtask

  // Build the expected beat list of a frame from the block rules, then start it.
  task automatic start_frame(input int blocks, input int bb, input int lb, input int pct);
    int k, n;
    beat_t b;
    frame_no++; src_rst = 1; mready_pct = pct;
    cfg_blocks = KW'(blocks); cfg_block_beats = BW'(bb); cfg_last_beats = BW'(lb);
    out_idx = 0; rel_count = 0; tlast_log.delete(); tuser_log.delete(); rel_log.delete();
    k = 0;
    for (int blk = 0; blk < blocks; blk++) begin
      n = (blk == blocks - 1) ? lb : bb;
      for (int i = 0; i < n; i++) begin
        b.d = mk_data(k); b.l = (i == n - 1); b.u = (i == n - 1) && (blk == blocks - 1);
        exp_q.push_back(b); k++;
      end
    end
    tick(); tick();
    pulse_start();
  endtask

  task automatic wait_done(input int blocks, input int limit);
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_frame_done && n < limit);
    if (!o_frame_done) begin
      checks++; errors++;
      $display("FAIL frame_done_timeout: no o_frame_done within %0d cycles", limit);
    end else begin
      chk("done_busy_low", o_busy, 1'b0);
      chk("done_beats_left", exp_q.size(), 0);
      chk("done_release_count", rel_count, blocks);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen, n;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_s_tready", s_axis.tready, 1'b0);
    chk("rst_status", {o_busy, o_frame_done, o_err, m_axis.tlast, m_axis.tuser}, 5'b0);
    chk("rst_release", o_bank_release, '0);
    chk("rst_bank_sel", o_bank_sel, '0);
    tick(); rstn = 1'b1; tick();

    // Basic frame: 4 blocks of 8, ready always high.
    err_cnt = 0;
    start_frame(4, 8, 8, 100);
    @(negedge clk); chk("basic_busy", o_busy, 1'b1);
    wait_done(4, 500);
    chk("basic_tlast_n", tlast_log.size(), 4);
    if (tlast_log.size() == 4) begin
      chk("basic_tlast0", tlast_log[0], 7);  chk("basic_tlast1", tlast_log[1], 15);
      chk("basic_tlast2", tlast_log[2], 23); chk("basic_tlast3", tlast_log[3], 31);
    end
    chk("basic_tuser_n", tuser_log.size(), 1);
    if (tuser_log.size() == 1) chk("basic_tuser_idx", tuser_log[0], 31);
    // 31 back-to-back beats plus RELEASE+WAIT_BANK at each of 3 boundaries.
    chk("basic_span", last_out - first_out, 37);
    chk("basic_rel_n", rel_log.size(), 4);
    if (rel_log.size() == 4) chk("basic_rel_order", {rel_log[0], rel_log[1], rel_log[2], rel_log[3]},
                                 {32'd0, 32'd1, 32'd2, 32'd0});
    chk("basic_no_err", err_cnt, 0);

    // Short last block: 16, 16, 5.
    start_frame(3, 16, 5, 100);
    wait_done(3, 500);
    chk("short_tlast_n", tlast_log.size(), 3);
    if (tlast_log.size() == 3) begin
      chk("short_tlast0", tlast_log[0], 15); chk("short_tlast1", tlast_log[1], 31);
      chk("short_tlast2", tlast_log[2], 36);
    end
    chk("short_tuser_n", tuser_log.size(), 1);
    if (tuser_log.size() == 1) chk("short_tuser_idx", tuser_log[0], 36);

    // Backpressure at 30% ready.
    start_frame(3, 6, 4, 30);
    wait_done(3, 3000);
    chk("bp_beats_out", out_idx, 16);

    // Bank starvation: bank 1 empty for 50 cycles after bank 0 releases.
    i_bank_full = 3'b101;
    start_frame(3, 4, 4, 100);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_bank_release[0] && n < 200);
    chk("starve_bank0_released", o_bank_release[0], 1'b1);
    repeat (50) begin
      @(negedge clk);
      chk("starve_sel", o_bank_sel, 2'd1);
      chk("starve_s_tready", s_axis.tready, 1'b0);
    end
    tick(); i_bank_full = 3'b111;
    @(negedge clk); chk("starve_still_waiting", s_axis.tready, 1'b0);
    @(negedge clk); chk("starve_resume", s_axis.tready, 1'b1);
    wait_done(3, 500);

    // Illegal starts with a zero config field.
    err_cnt = 0; busy_seen = 0;
    cfg_blocks = 0; cfg_block_beats = 8; cfg_last_beats = 8;
    pulse_start();
    repeat (6) begin @(negedge clk); if (o_busy) busy_seen++; end
    chk("zero_blocks_err", err_cnt, 1);
    chk("zero_blocks_busy", busy_seen, 0);
    tick();
    cfg_blocks = 2; cfg_block_beats = 0;
    pulse_start();
    repeat (6) begin @(negedge clk); if (o_busy) busy_seen++; end
    chk("zero_beats_err", err_cnt, 2);
    chk("zero_beats_busy", busy_seen, 0);
    tick();

    // Second start mid-frame: error pulse, frame unaffected.
    err_cnt = 0;
    start_frame(2, 8, 8, 100);
    tick(); tick(); tick();
    pulse_start();
    wait_done(2, 500);
    chk("midstart_err", err_cnt, 1);

    // Soft reset after beat 5 of block 1.
    start_frame(3, 8, 8, 100);
    n = 0;
    do begin @(negedge clk); n++; end while (src_cnt < 14 && n < 200);
    chk("soft_reached_beat", src_cnt >= 14, 1'b1);
    tick(); soft_rstn = 1'b0;
    tick(); soft_rstn = 1'b1;
    @(negedge clk);
    chk("soft_m_tvalid", m_axis.tvalid, 1'b0);
    chk("soft_busy", o_busy, 1'b0);
    chk("soft_release", o_bank_release, '0);
    chk("soft_bank_sel", o_bank_sel, '0);
    repeat (3) @(negedge clk);
    chk("soft_idle_tvalid", m_axis.tvalid, 1'b0);
    tick();
    start_frame(2, 8, 8, 100);
    wait_done(2, 500);
    chk("soft_restart_rel_n", rel_log.size(), 2);
    if (rel_log.size() == 2) chk("soft_restart_bank0", rel_log[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gdc_map_bank_reader.md
Name: gdc_map_bank_reader

Overview:
- Multi-bank successor to the GDC map read controller.
- Drains a frame of distortion-map data from NUM_BANKS round-robin buffer banks, filled by an upstream writer, into a full-throughput AXI4-Stream master.
- Block size, last-block size and block count are run-time configurable, latched at frame start.
- Adds per-block tlast, end-of-frame tuser, bank release handshake, error flag and synchronous soft reset.

Parameters:
- DATA_WIDTH, 128, stream data width in bits.
- NUM_BANKS, 2, number of buffer banks; must be ≥2.
- BEAT_W, 12, width of beats-per-block config; max 4095 beats.
- BLK_W, 12, width of blocks-per-frame config.
- SEL_W, $clog2(NUM_BANKS), bank index width; minimum 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- soft_rstn  in  1  synchronous active-low soft reset.
- i_start  in  1  frame start; rising edge is detected internally.
- cfg_blocks  in  BLK_W  blocks per frame.
- cfg_block_beats  in  BEAT_W  beats per normal block.
- cfg_last_beats  in  BEAT_W  beats in the final block.
- i_bank_full  in  NUM_BANKS  level; bank k holds a complete block.
- o_bank_sel  out  SEL_W  index of the bank being read; the external mux selects the s_axis source with it.
- o_bank_release  out  NUM_BANKS  one-cycle pulse; bank k drained.
- s_axis_tvalid  in  1  selected bank data valid.
- s_axis_tready  out  1  accept from selected bank.
- s_axis_tdata  in  DATA_WIDTH  selected bank data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tlast  out  1  last beat of a block.
- m_axis_tuser  out  1  last beat of the frame.
- o_busy  out  1  high from frame start until o_frame_done.
- o_frame_done  out  1  one-cycle pulse when the frame has fully left m_axis.
- o_err  out  1  one-cycle pulse on illegal start.

Behaviour:
- Reset (rstn low, async): every output is 0, state is IDLE, counters are 0, the skid buffer is empty.
- soft_rstn low: applies the same clear synchronously at the next edge. Buffered beats are dropped. No release pulse is issued.
- Start: a rising edge on i_start (registered 2-FF edge detect, so 1-cycle latency) in IDLE latches cfg_blocks, cfg_block_beats and cfg_last_beats.
  - The bank pointer and block counter are cleared, o_busy is set, and the FSM goes to WAIT_BANK.
- Illegal start: any latched cfg value of 0 pulses o_err and the FSM stays IDLE. A start edge outside IDLE pulses o_err and is otherwise ignored.
- FSM states: IDLE, WAIT_BANK, STREAM, RELEASE, DRAIN.
  - WAIT_BANK → STREAM when i_bank_full[ptr] is high.
  - STREAM: beat_cnt counts accepted input beats (s_axis_tvalid && s_axis_tready). Target is cfg_last_beats when blk_cnt == cfg_blocks-1, otherwise cfg_block_beats.
  - STREAM → RELEASE when the beat at index target-1 is accepted.
  - RELEASE (1 cycle): o_bank_release[ptr] pulses, ptr increments modulo NUM_BANKS, blk_cnt increments, beat_cnt is cleared.
  - After RELEASE: go to DRAIN if blk_cnt (new value) == cfg_blocks, otherwise WAIT_BANK.
  - DRAIN: wait for the skid buffer to be empty, then pulse o_frame_done, clear o_busy and return to IDLE.
- o_bank_sel = ptr, registered and stable for the whole block.
- Output stage: a 2-entry skid FIFO carries {data, last, user}.
  - s_axis_tready = (state == STREAM) && (fill < 2) && (beat_cnt < target).
  - s_axis_tready has no combinational path from m_axis_tready.
  - Latency is 1 cycle, input accept to m_axis_tvalid, when the FIFO is empty.
  - Sustained throughput is 1 beat/clk while m_axis_tready stays high.
- m_axis rules: tdata, tlast and tuser stay stable while tvalid && !tready. tvalid never drops without a handshake, except on reset or soft reset.
  - tlast is set on beat target-1 of every block.
  - tuser is set only on the final beat of the final block; tlast is also high on that beat.
- Simultaneous events:
  - Accept and output pop in the same cycle leave fill unchanged.
  - A bank's i_bank_full may still be high during RELEASE; it is ignored until that bank is next selected.
  - Config changes mid-frame are ignored.
- Counter widths: beat_cnt is BEAT_W and blk_cnt is BLK_W. Neither wraps within legal configs.

Test Plan:
- Basic frame: NUM_BANKS=2, cfg 4/8/8, banks always full, m_tready=1.
  - 32 beats out, 1 beat/clk with no gaps except WAIT_BANK/RELEASE.
  - tlast on beats 7, 15, 23, 31; tuser only on beat 31.
  - Release pulses in order bank 0,1,0,1; o_frame_done after the final beat.
- Short last block: cfg 3/16/5 → blocks of 16, 16 and 5 beats; tlast on beat 36; tuser on beat 36.
- Backpressure: random m_tready at 30% duty.
  - Output data equals the input sequence.
  - tdata/tlast/tuser are held while stalled; fill never exceeds 2.
  - s_tready is low whenever fill == 2.
- Bank starvation: NUM_BANKS=3; hold i_bank_full[1] low for 50 cycles after bank 0 releases.
  - FSM stays in WAIT_BANK, o_bank_sel=1, s_tready=0.
  - Streaming resumes exactly when bank 1 asserts.
- Errors: a start with cfg_blocks=0 gives o_err=1 for 1 cycle and o_busy stays 0. A second start mid-frame gives o_err and the frame completes unaffected.
- Soft reset mid-block: soft_rstn low for 1 cycle after beat 5 of block 1.
  - Next cycle: m_tvalid=0, o_busy=0, no release pulse.
  - A new start then begins at bank 0.
